// File: rtl/uart_tx_shifter_if.sv
// Byte handshake between a producer and the UART transmit shifter.
// The producer drives tx_data/tx_valid; the shifter answers with tx_ready.
interface uart_tx_shifter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_shifter.sv
// UART transmit shifter: 2-entry byte FIFO feeding a start/8-data/stop serialiser paced by baud_tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bits.
module uart_tx_shifter #(
  parameter int STOP_BITS = 1
) (
  input  logic             sysclk,
  input  logic             rst_n,
  uart_tx_shifter_if.slave tx_if,
  input  logic             baud_tick,
  output logic             baud_start,
  output logic             txd,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  state_e          state_q, state_d;
  logic [1:0][7:0] fifo_mem_q, fifo_mem_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            stop_cnt_q, stop_cnt_d;
  logic            txd_q, txd_d;
  logic            baud_start_q, baud_start_d;
  logic            frame_done_q, frame_done_d;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic tx_ready;
  logic accept;
  logic pop;

  assign tx_ready       = (count_q < 2'd2);
  assign accept         = tx_if.tx_valid && tx_ready;
  assign pop            = (state_q == IDLE) && (count_q != 2'd0);
  assign tx_if.tx_ready = tx_ready;
  assign busy           = (state_q != IDLE);
  assign txd            = txd_q;
  assign baud_start     = baud_start_q;
  assign frame_done     = frame_done_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fifo_mem_q   <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      shift_q      <= 8'd0;
      bit_cnt_q    <= 3'd0;
      stop_cnt_q   <= 1'b0;
      txd_q        <= 1'b1;
      baud_start_q <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fifo_mem_q   <= fifo_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      txd_q        <= txd_d;
      baud_start_q <= baud_start_d;
      frame_done_q <= frame_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // Simultaneous accept and pop leave the occupancy unchanged.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (accept) begin
      fifo_mem_d[wr_ptr_q] = tx_if.tx_data;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = START;
          shift_d = fifo_mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_mem_q[rd_ptr_q];
`endif
        end
      end
      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          shift_d   = shift_q >> 1;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        // The shift register is one bit ahead of txd, so shift_q[0] is always the next bit.
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            stop_cnt_d = 1'b0;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d    = IDLE;
            stop_cnt_d = 1'b0;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    txd_d        = txd_q;
    baud_start_d = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          txd_d        = 1'b0;
          baud_start_d = 1'b1;
        end else begin
          txd_d = 1'b1;
        end
      end
      START: begin
        if (baud_tick) txd_d = shift_q[0];
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_d = parity_q;
`else
            txd_d = 1'b1;
`endif
          end else begin
            txd_d = shift_q[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) txd_d = 1'b1;
      end
`endif
      STOP: begin
        if (baud_tick && (stop_cnt_q == STOP_LAST)) frame_done_d = 1'b1;
      end
      default: txd_d = 1'b1;
    endcase
  end

endmodule
